// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg: shared state encoding, default data width and clog2 helper for the FIFO write arbiter.
package fifo_ctrl_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    function automatic int clog2(input int n);
        int r;
        for (r = 0; (1 << r) < n; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester handshake and FIFO write-side bus of the arbiter.
//   req_valid/req_data/req_ready : per-requester valid/ready beat handshake
//   fifo_full/fifo_write_en/fifo_data_in : FIFO write port
//   grant_valid/grant_id : current ownership status
//   master = arbiter side, slave = requesters + FIFO side
interface fifo_wr_arbiter_if
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_REQ    = 4
);
    localparam int IW = clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_write_en;
    logic [DATA_WIDTH-1:0]         fifo_data_in;
    logic                          grant_valid;
    logic [IW-1:0]                 grant_id;

    modport master (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_write_en, fifo_data_in, grant_valid, grant_id
    );

    modport slave (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_write_en, fifo_data_in, grant_valid, grant_id
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority picker; finds the first set req bit after base, wrapping.
//   req   : request vector
//   base  : index with lowest priority (search starts at base+1)
//   found : any request set
//   idx   : winning index
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] base,
    output logic         found,
    output logic [W-1:0] idx
);
    logic [W-1:0] j;

    // Scan from farthest to nearest so the nearest hit after base overwrites the rest.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = '0;
        for (int k = N; k >= 1; k--) begin
            j = W'((int'(base) + k) % N);
            if (req[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : requester handshakes, FIFO write port and grant status (master side)
module fifo_wr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_REQ    = 4,
    parameter int BURST_LEN  = 4
) (
    input logic               clk,
    input logic               rst_n,
    fifo_wr_arbiter_if.master bus
);
    localparam int IW = clog2(NUM_REQ);
    localparam int BW = clog2(BURST_LEN + 1);

    state_e          state_q, state_d;
    logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;
    logic [IW-1:0]   last_owner_q, last_owner_d;
    logic [IW-1:0]   pick_id;
    logic            pick_found;
    logic            own_valid;
    logic            wr;

    rr_pick #(.N(NUM_REQ), .W(IW)) u_pick (
        .req   (bus.req_valid),
        .base  (last_owner_q),
        .found (pick_found),
        .idx   (pick_id)
    );

    always_comb begin
        state_d           = state_q;
        beat_cnt_d        = beat_cnt_q;
        grant_id_d        = grant_id_q;
        last_owner_d      = last_owner_q;
        bus.req_ready     = '0;
        bus.fifo_data_in  = '0;
        own_valid         = 1'b0;
        wr                = 1'b0;
        if (state_q == ST_IDLE) begin
            if (pick_found) begin
                state_d    = ST_GRANT;
                grant_id_d = pick_id;
                beat_cnt_d = '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_id_q == IW'(i)) begin
                    bus.req_ready[i] = ~bus.fifo_full;
                    own_valid        = bus.req_valid[i];
                    bus.fifo_data_in = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            wr = own_valid & ~bus.fifo_full;
            // Owner dropping valid releases even while full; otherwise release on the last burst beat.
            if (!own_valid || (wr && beat_cnt_q == BW'(BURST_LEN - 1))) begin
                state_d      = ST_IDLE;
                last_owner_d = grant_id_q;
                beat_cnt_d   = '0;
            end else if (wr) begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
    end

    assign bus.fifo_write_en = wr;
    assign bus.grant_valid   = (state_q == ST_GRANT);
    assign bus.grant_id      = grant_id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            beat_cnt_q   <= '0;
            grant_id_q   <= '0;
            last_owner_q <= IW'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            grant_id_q   <= grant_id_d;
            last_owner_q <= last_owner_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scenario-based self-checking bench with a write scoreboard for fifo_wr_arbiter.
module tb_fifo_wr_arbiter;
    import fifo_ctrl_pkg::*;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.DATA_WIDTH(8), .NUM_REQ(4)) bus ();

    fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .BURST_LEN(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    beat_t      exp_q[$];
    logic [7:0] rq[4][$];
    int         checks = 0;
    int         passed = 0;
    logic       gv_l[64];
    logic       we_l[64];
    logic [1:0] gid_l[64];
    logic [3:0] rdy_l[64];
    logic [2:0] bc_l[64];
    logic [15:0] out_l[64];

    // Drive requesters from their queues at negedge, sample 1ns later, score writes, retire accepted beats.
    task automatic run(input int n, input logic [63:0] full_pat, input logic [63:0] rst_pat);
        beat_t e;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rst_n = ~rst_pat[c];
            bus.fifo_full = full_pat[c];
            for (int i = 0; i < 4; i++) begin
                bus.req_valid[i] = rq[i].size() > 0;
                bus.req_data[i*8 +: 8] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
            end
            #1;
            gv_l[c]  = bus.grant_valid;
            we_l[c]  = bus.fifo_write_en;
            gid_l[c] = bus.grant_id;
            rdy_l[c] = bus.req_ready;
            bc_l[c]  = dut.beat_cnt_q;
            out_l[c] = {bus.grant_valid, bus.fifo_write_en, bus.req_ready, bus.fifo_data_in, bus.grant_id};
            if (bus.fifo_write_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_extra: got id=%0d data=%h, required no write", bus.grant_id, bus.fifo_data_in);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.grant_id !== e.id || bus.fifo_data_in !== e.data)
                        $display("FAIL sb_beat: got id=%0d data=%h, required id=%0d data=%h",
                                 bus.grant_id, bus.fifo_data_in, e.id, e.data);
                    else passed++;
                end
            end
            for (int i = 0; i < 4; i++)
                if (bus.req_ready[i] && bus.req_valid[i]) void'(rq[i].pop_front());
        end
    endtask

    task automatic do_reset();
        run(2, 64'h0, 64'h3);
    endtask

    task automatic test_reset();
        run(2, 64'h0, 64'h3);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (out_l[c] !== 16'h0) $display("FAIL reset_outputs c%0d: got %h, required 0000", c, out_l[c]);
            else passed++;
        end
        run(3, 64'h0, 64'h0);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (gv_l[c] !== 1'b0 || we_l[c] !== 1'b0 || gid_l[c] !== 2'd0)
                $display("FAIL idle_noreq c%0d: got gv=%b we=%b gid=%0d, required 0 0 0", c, gv_l[c], we_l[c], gid_l[c]);
            else passed++;
        end
    endtask

    task automatic test_single();
        logic [63:0] gp, wp;
        logic [7:0] d[5] = '{8'h05, 8'h0A, 8'h0F, 8'h14, 8'h19};
        do_reset();
        foreach (d[k]) begin
            rq[1].push_back(d[k]);
            exp_q.push_back('{id: 2'd1, data: d[k]});
        end
        gp = 64'hDE;
        wp = 64'h5E;
        run(9, 64'h0, 64'h0);
        for (int c = 0; c < 9; c++) begin
            checks++;
            if (gv_l[c] !== gp[c] || we_l[c] !== wp[c])
                $display("FAIL single_timing c%0d: got gv=%b we=%b, required gv=%b we=%b", c, gv_l[c], we_l[c], gp[c], wp[c]);
            else passed++;
        end
        checks++;
        if (gid_l[6] !== 2'd1) $display("FAIL single_regrant: got id=%0d, required 1", gid_l[6]);
        else passed++;
        checks++;
        if (exp_q.size() != 0) $display("FAIL single_drain: got %0d pending, required 0", exp_q.size());
        else passed++;
    endtask

    task automatic test_round_robin();
        logic [63:0] gp, wp;
        logic [1:0] want;
        do_reset();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                rq[i].push_back(8'(16 * i + k));
                exp_q.push_back('{id: 2'(i), data: 8'(16 * i + k)});
            end
        rq[0].push_back(8'h04);
        exp_q.push_back('{id: 2'd0, data: 8'h04});
        gp = '0;
        wp = '0;
        for (int g = 0; g < 4; g++)
            for (int k = 0; k < 4; k++) begin
                gp[5*g+1+k] = 1'b1;
                wp[5*g+1+k] = 1'b1;
            end
        gp[21] = 1'b1;
        gp[22] = 1'b1;
        wp[21] = 1'b1;
        run(24, 64'h0, 64'h0);
        for (int c = 0; c < 24; c++) begin
            checks++;
            if (gv_l[c] !== gp[c] || we_l[c] !== wp[c])
                $display("FAIL rr_timing c%0d: got gv=%b we=%b, required gv=%b we=%b", c, gv_l[c], we_l[c], gp[c], wp[c]);
            else passed++;
        end
        for (int g = 0; g < 5; g++) begin
            want = 2'(g % 4);
            checks++;
            if (gid_l[5*g+1] !== want) $display("FAIL rr_order g%0d: got id=%0d, required %0d", g, gid_l[5*g+1], want);
            else passed++;
        end
        checks++;
        if (exp_q.size() != 0) $display("FAIL rr_drain: got %0d pending, required 0", exp_q.size());
        else passed++;
    endtask

    task automatic test_full_stall();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            rq[0].push_back(8'(8'hA0 + k));
            exp_q.push_back('{id: 2'd0, data: 8'(8'hA0 + k)});
        end
        run(10, 64'h38, 64'h0);
        for (int c = 3; c < 6; c++) begin
            checks++;
            if (we_l[c] !== 1'b0 || rdy_l[c] !== 4'h0 || bc_l[c] !== 3'd2 || gv_l[c] !== 1'b1)
                $display("FAIL full_hold c%0d: got we=%b rdy=%h cnt=%0d gv=%b, required 0 0 2 1",
                         c, we_l[c], rdy_l[c], bc_l[c], gv_l[c]);
            else passed++;
        end
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (gv_l[c] !== ((c >= 1 && c <= 7) ? 1'b1 : 1'b0) || we_l[c] !== ((c == 1 || c == 2 || c == 6 || c == 7) ? 1'b1 : 1'b0))
                $display("FAIL full_timing c%0d: got gv=%b we=%b", c, gv_l[c], we_l[c]);
            else passed++;
        end
        checks++;
        if (exp_q.size() != 0) $display("FAIL full_drain: got %0d pending, required 0", exp_q.size());
        else passed++;
    endtask

    task automatic test_drop_valid();
        logic [63:0] gp, wp;
        do_reset();
        rq[1].push_back(8'h51);
        exp_q.push_back('{id: 2'd1, data: 8'h51});
        run(3, 64'h0, 64'h0);
        checks++;
        if (gid_l[1] !== 2'd1 || we_l[1] !== 1'b1) $display("FAIL drop_setup: got id=%0d we=%b, required 1 1", gid_l[1], we_l[1]);
        else passed++;
        rq[2].push_back(8'h62); rq[2].push_back(8'h63);
        rq[3].push_back(8'h73); rq[3].push_back(8'h74);
        rq[0].push_back(8'h05); rq[0].push_back(8'h06);
        exp_q.push_back('{id: 2'd2, data: 8'h62}); exp_q.push_back('{id: 2'd2, data: 8'h63});
        exp_q.push_back('{id: 2'd3, data: 8'h73}); exp_q.push_back('{id: 2'd3, data: 8'h74});
        exp_q.push_back('{id: 2'd0, data: 8'h05}); exp_q.push_back('{id: 2'd0, data: 8'h06});
        gp = 64'hEEE;
        wp = 64'h666;
        run(13, 64'h0, 64'h0);
        for (int c = 0; c < 13; c++) begin
            checks++;
            if (gv_l[c] !== gp[c] || we_l[c] !== wp[c])
                $display("FAIL drop_timing c%0d: got gv=%b we=%b, required gv=%b we=%b", c, gv_l[c], we_l[c], gp[c], wp[c]);
            else passed++;
        end
        checks++;
        if (gid_l[1] !== 2'd2 || gid_l[5] !== 2'd3 || gid_l[9] !== 2'd0)
            $display("FAIL drop_order: got %0d,%0d,%0d, required 2,3,0", gid_l[1], gid_l[5], gid_l[9]);
        else passed++;
        checks++;
        if (exp_q.size() != 0) $display("FAIL drop_drain: got %0d pending, required 0", exp_q.size());
        else passed++;
    endtask

    task automatic test_reset_mid_burst();
        logic [63:0] gp, wp;
        do_reset();
        for (int k = 0; k < 4; k++) rq[1].push_back(8'(8'h81 + k));
        exp_q.push_back('{id: 2'd1, data: 8'h81});
        exp_q.push_back('{id: 2'd1, data: 8'h82});
        run(3, 64'h0, 64'h0);
        rq[3].push_back(8'h91);
        exp_q.push_back('{id: 2'd1, data: 8'h83});
        exp_q.push_back('{id: 2'd1, data: 8'h84});
        exp_q.push_back('{id: 2'd3, data: 8'h91});
        gp = 64'hDC;
        wp = 64'h4C;
        run(9, 64'h0, 64'h1);
        checks++;
        if (out_l[0] !== 16'h0) $display("FAIL midrst_outputs: got %h, required 0000", out_l[0]);
        else passed++;
        for (int c = 0; c < 9; c++) begin
            checks++;
            if (gv_l[c] !== gp[c] || we_l[c] !== wp[c])
                $display("FAIL midrst_timing c%0d: got gv=%b we=%b, required gv=%b we=%b", c, gv_l[c], we_l[c], gp[c], wp[c]);
            else passed++;
        end
        checks++;
        if (gid_l[2] !== 2'd1 || gid_l[6] !== 2'd3)
            $display("FAIL midrst_order: got %0d,%0d, required 1,3", gid_l[2], gid_l[6]);
        else passed++;
        checks++;
        if (exp_q.size() != 0) $display("FAIL midrst_drain: got %0d pending, required 0", exp_q.size());
        else passed++;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.fifo_full = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_drop_valid();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
